// File: rtl/vga_grid_renderer_pkg.sv
// vga_grid_pkg: shared types and default colours for the grid renderer.
package vga_grid_pkg;
    typedef logic [23:0] rgb_t;
    typedef enum logic [1:0] {PX_BLANK, PX_OUT, PX_BORDER, PX_INTERIOR} px_class_t;
    typedef struct packed {
        logic      hs;
        logic      vs;
        logic      de;
        px_class_t cls;
        logic      cur;
    } stage_t;
    localparam stage_t STAGE_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0, cls: PX_BLANK, cur: 1'b0};
    localparam rgb_t COL_OUT_DEF    = 24'hFF0000;
    localparam rgb_t COL_BORDER_DEF = 24'h00FF00;
    localparam rgb_t COL_CURSOR_DEF = 24'hFFFF00;
    localparam rgb_t COL_ALIVE_DEF  = 24'hFFFFFF;
    localparam rgb_t COL_DEAD_DEF   = 24'h000000;
endpackage

// File: rtl/vga_grid_renderer_if.sv
// vga_grid_renderer_if: synchronous-read cell RAM port (data valid one cycle after rd).
interface vga_grid_renderer_if #(parameter int ADDR_W = 4);
    logic [ADDR_W-1:0] cell_addr;
    logic              cell_rd;
    logic              cell_data;
    modport master (output cell_addr, cell_rd, input cell_data);
    modport slave  (input cell_addr, cell_rd, output cell_data);
endinterface

// File: rtl/vga_grid_renderer_axis_counter.sv
// vga_axis_counter: one timing axis - position, sync, active flag and incremental cell tracking.
module vga_axis_counter #(
    parameter int CELL   = 160,
    parameter int GRID   = 4,
    parameter int BORDER = 10,
    parameter int STRIDE = 1,
    parameter int AW     = 4
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          adv,
    input  logic [11:0]   total,
    input  logic [11:0]   sync,
    input  logic [11:0]   start,
    input  logic [11:0]   stop,
    output logic          sync_raw,
    output logic          act,
    output logic          border,
    output logic          wrap,
    output logic [6:0]    idx,
    output logic [AW-1:0] base
);
    localparam logic [11:0]   C_LAST = 12'(CELL - 1);
    localparam logic [11:0]   B_LO   = 12'(BORDER);
    localparam logic [11:0]   B_HI   = 12'(CELL - BORDER);
    localparam logic [6:0]    G      = 7'(GRID);
    localparam logic [AW-1:0] STEP   = AW'(STRIDE);
    logic [11:0]   count_q, count_d, pos_q, pos_d;
    logic [6:0]    idx_q, idx_d;
    logic [AW-1:0] base_q, base_d;
    logic          restart, cell_end;
    always_comb begin
        wrap     = adv && count_q >= total;
        count_d  = !adv ? count_q : wrap ? 12'd0 : count_q + 12'd1;
        restart  = adv && count_d == start;
        cell_end = adv && pos_q == C_LAST;
        pos_d    = restart || cell_end ? 12'd0 : adv ? pos_q + 12'd1 : pos_q;
        idx_d    = restart ? 7'd0 : cell_end && idx_q != G ? idx_q + 7'd1 : idx_q;
        // base stops at the last cell so the RAM address can never leave the grid
        base_d   = restart ? '0 : cell_end && idx_q < G - 7'd1 ? base_q + STEP : base_q;
        sync_raw = count_q >= sync && count_q != total;
        act      = count_q >= start && count_q < stop;
        border   = pos_q < B_LO || pos_q >= B_HI;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            pos_q   <= '0;
            idx_q   <= '0;
            base_q  <= '0;
        end else begin
            count_q <= count_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
        end
    end
    assign idx  = idx_q;
    assign base = base_q;
endmodule

// File: rtl/vga_grid_renderer.sv
// vga_grid_renderer: runtime-timed VGA generator tiling a cell grid fetched from external RAM.
module vga_grid_renderer
    import vga_grid_pkg::*;
#(
    parameter int   GRID_W     = 4,
    parameter int   GRID_H     = 4,
    parameter int   CELL_W     = 160,
    parameter int   CELL_H     = 120,
    parameter int   BORDER     = 10,
    parameter int   ADDR_W     = 4,
    parameter rgb_t COL_OUT    = COL_OUT_DEF,
    parameter rgb_t COL_BORDER = COL_BORDER_DEF,
    parameter rgb_t COL_CURSOR = COL_CURSOR_DEF,
    parameter rgb_t COL_ALIVE  = COL_ALIVE_DEF,
    parameter rgb_t COL_DEAD   = COL_DEAD_DEF
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] h_total,
    input  logic [11:0] h_sync,
    input  logic [11:0] h_start,
    input  logic [11:0] h_end,
    input  logic [11:0] v_total,
    input  logic [11:0] v_sync,
    input  logic [11:0] v_start,
    input  logic [11:0] v_end,
    input  logic [5:0]  cur_x,
    input  logic [5:0]  cur_y,
    vga_grid_renderer_if.master ram,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);
    localparam logic [6:0] GW = 7'(GRID_W);
    localparam logic [6:0] GH = 7'(GRID_H);
    logic              h_sync_raw, h_act, h_border, h_wrap;
    logic              v_sync_raw, v_act, v_border, v_wrap;
    logic [6:0]        col, row;
    logic [ADDR_W-1:0] col_base, row_base;
    logic              in_grid, rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [5:0]        curx_q, curx_d, cury_q, cury_d;
    stage_t            s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    rgb_t              rgb_q, rgb_d;

    vga_axis_counter #(.CELL(CELL_W), .GRID(GRID_W), .BORDER(BORDER), .STRIDE(1), .AW(ADDR_W)) u_h (
        .clk(clk), .reset_n(reset_n), .adv(1'b1),
        .total(h_total), .sync(h_sync), .start(h_start), .stop(h_end),
        .sync_raw(h_sync_raw), .act(h_act), .border(h_border), .wrap(h_wrap),
        .idx(col), .base(col_base)
    );
    vga_axis_counter #(.CELL(CELL_H), .GRID(GRID_H), .BORDER(BORDER), .STRIDE(GRID_W), .AW(ADDR_W)) u_v (
        .clk(clk), .reset_n(reset_n), .adv(h_wrap),
        .total(v_total), .sync(v_sync), .start(v_start), .stop(v_end),
        .sync_raw(v_sync_raw), .act(v_act), .border(v_border), .wrap(v_wrap),
        .idx(row), .base(row_base)
    );

    always_comb begin
        frame_start = h_wrap && v_wrap;
        curx_d      = frame_start ? cur_x : curx_q;
        cury_d      = frame_start ? cur_y : cury_q;
        in_grid     = h_act && v_act && col < GW && row < GH;
        rd_d        = in_grid;
        addr_d      = in_grid ? row_base + col_base : addr_q;
        s1_d        = '{hs: h_sync_raw, vs: v_sync_raw, de: h_act && v_act,
                        cls: !(h_act && v_act) ? PX_BLANK : !in_grid ? PX_OUT :
                             h_border || v_border ? PX_BORDER : PX_INTERIOR,
                        cur: in_grid && col == {1'b0, curx_q} && row == {1'b0, cury_q}};
        s2_d        = s1_q;
        s3_d        = s2_q;
        // cell_data belongs to the pixel now in stage 2
        rgb_d       = s2_q.cls == PX_BLANK  ? '0 :
                      s2_q.cls == PX_OUT    ? COL_OUT :
                      s2_q.cls == PX_BORDER ? (s2_q.cur ? COL_CURSOR : COL_BORDER) :
                      ram.cell_data         ? COL_ALIVE : COL_DEAD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            curx_q <= '0;
            cury_q <= '0;
            rd_q   <= 1'b0;
            addr_q <= '0;
            s1_q   <= STAGE_RST;
            s2_q   <= STAGE_RST;
            s3_q   <= STAGE_RST;
            rgb_q  <= '0;
        end else begin
            curx_q <= curx_d;
            cury_q <= cury_d;
            rd_q   <= rd_d;
            addr_q <= addr_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            rgb_q  <= rgb_d;
        end
    end

    assign ram.cell_rd   = rd_q;
    assign ram.cell_addr = addr_q;
    assign vga_hs        = s3_q.hs;
    assign vga_vs        = s3_q.vs;
    assign vga_de        = s3_q.de;
    assign {vga_r, vga_g, vga_b} = rgb_q;
endmodule

// File: tb/tb_vga_grid_renderer.sv
// tb_vga_grid_renderer: scoreboard bench with a divide/modulo reference model of the pixel stream.
module tb_vga_grid_renderer;
    localparam int GW = 2, GH = 2, CW = 6, CH = 4, BD = 1;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] h_total = 12'd19, h_sync = 12'd2, h_start = 12'd4, h_end = 12'd16;
    logic [11:0] v_total = 12'd11, v_sync = 12'd1, v_start = 12'd2, v_end = 12'd10;
    logic [5:0]  cur_x = 6'd2, cur_y = 6'd2;
    logic        frame_start, vga_hs, vga_vs, vga_de;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [3:0]  mem = 4'b1000;

    exp_t sb[$];
    int   n_chk = 0, n_err = 0;
    int   mh, mv, sx, sy, prev_addr, fs_cnt;
    logic prev_rd;

    vga_grid_renderer_if #(.ADDR_W(4)) ram ();

    vga_grid_renderer #(.GRID_W(GW), .GRID_H(GH), .CELL_W(CW), .CELL_H(CH), .BORDER(BD), .ADDR_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
        .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
        .cur_x(cur_x), .cur_y(cur_y), .ram(ram),
        .frame_start(frame_start), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram.cell_rd) ram.cell_data <= mem[ram.cell_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at h=%0d v=%0d: got %h expected %h", tag, mh, mv, got, want);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; sx = 0; sy = 0; prev_rd = 1'b0; prev_addr = 0;
        sb.delete();
        repeat (3) sb.push_back('{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 24'h0});
    endtask

    task automatic step();
        exp_t e, got;
        int   x, y, col, row, px, py;
        logic hact, vact, ing, bd, fs;
        hact = mh >= int'(h_start) && mh < int'(h_end);
        vact = mv >= int'(v_start) && mv < int'(v_end);
        e.hs = mh >= int'(h_sync) && mh != int'(h_total);
        e.vs = mv >= int'(v_sync) && mv != int'(v_total);
        e.de = hact && vact;
        e.rgb = 24'h0;
        ing = 1'b0; col = 0; row = 0;
        if (e.de) begin
            x = mh - int'(h_start); y = mv - int'(v_start);
            col = x / CW; row = y / CH;
            ing = col < GW && row < GH;
            if (!ing) e.rgb = 24'hFF0000;
            else begin
                px = x % CW; py = y % CH;
                bd = px < BD || px >= CW - BD || py < BD || py >= CH - BD;
                e.rgb = bd ? ((col == sx && row == sy) ? 24'hFFFF00 : 24'h00FF00)
                           : (mem[row * GW + col] ? 24'hFFFFFF : 24'h000000);
            end
        end
        sb.push_back(e);
        got = sb.pop_front();
        check("hs", 32'(vga_hs), 32'(got.hs));
        check("vs", 32'(vga_vs), 32'(got.vs));
        check("de", 32'(vga_de), 32'(got.de));
        check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(got.rgb));
        check("cell_rd", 32'(ram.cell_rd), 32'(prev_rd));
        if (prev_rd) check("cell_addr", 32'(ram.cell_addr), 32'(prev_addr));
        check("addr_range", 32'(ram.cell_addr <= 4'd3), 32'd1);
        fs = mh == int'(h_total) && mv == int'(v_total);
        check("frame_start", 32'(frame_start), 32'(fs));
        fs_cnt += int'(frame_start);
        prev_rd = ing;
        prev_addr = row * GW + col;
        if (fs) begin sx = int'(cur_x); sy = int'(cur_y); end
        if (mh == int'(h_total)) begin
            mh = 0;
            mv = (mv == int'(v_total)) ? 0 : mv + 1;
        end else mh++;
    endtask

    task automatic run(input int n);
        repeat (n) begin @(negedge clk); step(); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_hs", 32'(vga_hs), 32'd1);
        check("rst_vs", 32'(vga_vs), 32'd1);
        check("rst_de", 32'(vga_de), 32'd0);
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check("rst_rd", 32'(ram.cell_rd), 32'd0);
        check("rst_addr", 32'(ram.cell_addr), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        model_reset();
        step();
    endtask

    initial begin
        mh = 0; mv = 0; fs_cnt = 0;
        do_reset();
        run(479);
        check("fs_count", 32'(fs_cnt), 32'd2);
        run(100);
        cur_x = 6'd1; cur_y = 6'd0;
        run(380);
        mem = 4'b0110;
        h_end = 12'd18;
        run(480);
        run(310);
        fs_cnt = 0;
        do_reset();
        run(479);
        check("fs_count_after_reset", 32'(fs_cnt), 32'd2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_grid_renderer.md
Name: vga_grid_renderer

Overview:
- Parametrised successor to the fixed 4x4 grid VGA generator for the Game of Life display.
- Generates HS/VS/DE from runtime timing inputs and tiles a GRID_W x GRID_H cell grid into the active area.
- Fetches each cell's alive/dead state from an external synchronous-read cell RAM owned by the life engine, and highlights a cursor cell.
- Emits a frame-boundary pulse so the engine can swap buffers without tearing.

Parameters:
GRID_W, 4, grid columns (1..64)
GRID_H, 4, grid rows (1..64)
CELL_W, 160, cell width in pixels (>2*BORDER)
CELL_H, 120, cell height in pixels (>2*BORDER)
BORDER, 10, cell border thickness in pixels
ADDR_W, 4, cell RAM address width; must satisfy 2**ADDR_W >= GRID_W*GRID_H
COL_OUT, 24'hFF0000, colour for active pixels outside the grid
COL_BORDER, 24'h00FF00, colour for normal cell borders
COL_CURSOR, 24'hFFFF00, colour for the cursor cell border
COL_ALIVE, 24'hFFFFFF, colour for an alive cell interior
COL_DEAD, 24'h000000, colour for a dead cell interior

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
h_total,h_sync,h_start,h_end  in  12 each  horizontal timing; last count, sync end, active start, active end (exclusive)
v_total,v_sync,v_start,v_end  in  12 each  vertical timing, same meaning in lines
cur_x  in  6  cursor column
cur_y  in  6  cursor row
cell_addr  out  ADDR_W  cell RAM read address
cell_rd  out  1  cell RAM read strobe
cell_data  in  1  RAM read data; valid exactly 1 cycle after cell_rd
frame_start  out  1  one-cycle pulse at end of frame
vga_hs,vga_vs,vga_de  out  1 each  syncs (active low) and data enable
vga_r,vga_g,vga_b  out  8 each  pixel colour

Behaviour:
- Reset values (asynchronous): all counters 0; vga_hs=1, vga_vs=1, vga_de=0, rgb=0, cell_rd=0, cell_addr=0, frame_start=0. Reset mid-frame restarts at h=0, v=0; first frame after reset is not guaranteed complete.
- Stage 0, counters:
  - h_count 0..h_total, wraps to 0.
  - v_count advances only when h_count==h_total, 0..v_total, wraps to 0.
  - hs_raw = (h_count>=h_sync) && (h_count!=h_total); vs_raw is the same with v terms.
  - h_act is true for h_count in [h_start,h_end); v_act is true for v_count in [v_start,v_end).
- Cell tracking uses incremental counters only; no divide, modulo or multiply.
  - px_in_cell/col reset to 0 at h_start; px_in_cell wraps at CELL_W-1 and increments col; col saturates at GRID_W, meaning outside the grid.
  - py_in_cell/row/row_base reset at v_start and update once per line; row_base += GRID_W on each row advance.
- Stage 1, fetch:
  - in_grid = h_act && v_act && col<GRID_W && row<GRID_H.
  - cell_rd = in_grid; cell_addr = row_base+col, registered.
  - Also registered: pixel class (blank / out / border / interior), is_cursor = (col==cur_x && row==cur_y).
- Stage 2, colour select (cell_data arrives this cycle):
  - blank gives rgb 0.
  - out gives COL_OUT.
  - border gives COL_CURSOR if is_cursor, else COL_BORDER.
  - interior gives COL_ALIVE if cell_data, else COL_DEAD.
- Border test: px_in_cell<BORDER or px_in_cell>=CELL_W-BORDER, or the same test vertically.
- Latency: syncs, de and rgb are all delayed 3 clocks from stage-0 counters, so the outputs stay mutually aligned; vga_de = delayed (h_act && v_act).
- cur_x/cur_y are sampled into shadow registers only on frame_start, so the cursor never tears mid-frame. Reset value of the shadows is 0.
- frame_start pulses for 1 cycle when h_count==h_total && v_count==v_total, undelayed, for the engine.
- Out-of-range cursor (cur_x>=GRID_W) means no cell is highlighted.
- Grid larger than the active area: cells are clipped; the address never exceeds GRID_W*GRID_H-1.
- Timing inputs are quasi-static; a change takes effect on the next count and may corrupt one frame only.

Decomposition:
- Package vga_grid_pkg holds:
  - pixel-class enum {PX_BLANK, PX_OUT, PX_BORDER, PX_INTERIOR}
  - 24-bit colour typedef
  - default colour constants
- One sub-module, vga_axis_counter, is instantiated twice (h and v). It contains the position counter, sync, active flag, and the in-cell/cell-index counters. Its advance enable is tied to 1 for h and to h wrap for v.

Test Plan:
- Small timing (h_total=19,h_sync=2,h_start=4,h_end=16; v_total=11,v_sync=1,v_start=2,v_end=10), GRID 2x2, CELL 6x4, BORDER 1 -> hs low for counts 0,1 and 19; de high 12 px/line for 8 lines; all outputs aligned 3 cycles after counters.
- Same setup, RAM model returns alive for address 3 only -> interior pixels of cell (1,1) are FFFFFF; other interiors 000000; borders 00FF00.
- cur_x=1,cur_y=0 changed mid-frame -> highlight appears only after next frame_start; then cell (1,0) border is FFFF00.
- h_end=18 (wider than grid) -> active pixels 12..13 are FF0000; cell_rd=0 there; cell_addr never exceeds 3.
- frame_start check -> exactly one pulse per (20*12)=240 clocks, coincident with h=19,v=11.
- Assert reset_n low mid-line for 2 cycles -> outputs immediately hs=1,vs=1,de=0,rgb=0; counting restarts at 0 after release.
